mux_ac_acum: RTL and testbench
==============================

Name: mux_ac_acum

Overview:
- Parametrised, registered successor to the filter's accumulator-input selector.
- Holds CH independent signed 2N-bit accumulators, one per filter channel. Each accepted sample applies one of four modes to the addressed channel: load Uk, accumulate Uk, clear, or hold.
- Adds saturation, sticky overflow flags, a valid handshake and a global clear.
- Sits between the coefficient multiplier (Uk) and the filter output stage.

Parameters:
- N, 25, half-width; data and accumulators are 2N bits signed two's-complement.
- CH, 4, number of channel accumulators (1..2^CW).
- CW, 2, channel index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- clear_all  in  1  synchronous clear of every accumulator and overflow flag.
- in_valid  in  1  sample strobe; select/ch/Uk sampled when high.
- select  in  2  mode: 00 load Uk, 01 accumulate (acc+Uk), 10 clear to 0, 11 hold.
- ch  in  CW  target channel.
- Uk  in  2N  signed input product.
- Y  out  2N  registered new value of the addressed accumulator.
- out_valid  out  1  high one cycle after an accepted sample.
- out_ch  out  CW  channel that Y belongs to.
- ovf  out  CH  per-channel sticky saturation flag.
- rd_ch  in  CW  debug read channel.
- rd_acc  out  2N  combinational view of accumulator rd_ch.

Behaviour:
- Reset (reset=0, async):
  - all accumulators = 0, Y = 0, out_valid = 0, out_ch = 0, ovf = 0.
  - Takes effect immediately, even mid-operation; no pending result survives.
- Accept: on a rising clk with reset=1, clear_all=0, in_valid=1 and ch<CH, channel ch is updated per select:
  - 00: acc[ch] <= Uk.
  - 01: acc[ch] <= sat(acc[ch] + Uk).
  - 10: acc[ch] <= 0 and ovf[ch] <= 0.
  - 11: acc[ch] unchanged.
- Outputs for an accepted sample (all modes, including hold):
  - Y <= the new acc[ch] value; out_ch <= ch; out_valid <= 1.
  - Latency is exactly 1 cycle. One sample per cycle is allowed; there is no backpressure.
- Idle cycle (in_valid=0): out_valid <= 0. Y and out_ch hold their last values. Accumulators are unchanged.
- Out-of-range channel (ch>=CH): the sample is ignored, out_valid <= 0, no state changes.
- Saturation: the sum is formed at 2N+1 bits.
  - If the sum exceeds 2^(2N-1)-1, the result is 2^(2N-1)-1.
  - If the sum is below -2^(2N-1), the result is -2^(2N-1).
  - Either case sets ovf[ch] <= 1.
- ovf[ch] is sticky. It clears only on reset, clear_all, or select=10 on that channel. Load (00) does not clear it.
- clear_all=1 has priority over in_valid:
  - all accumulators and ovf are set to 0.
  - out_valid <= 0 and Y <= 0. The coincident sample is dropped.
- Channels are fully independent; an update to one channel never alters another.
- Back-to-back accumulate to the same channel uses the value written the previous cycle; no hazard bubble is permitted.
- rd_acc = acc[rd_ch], combinational. It returns 0 for rd_ch>=CH.

Test Plan:
- Reset release: reset low for 3 cycles with in_valid toggling, then high → Y=0, out_valid=0, ovf=0, rd_acc=0 for all channels.
- Load/accumulate: ch1, select=00, Uk=100; then three cycles of select=01 with Uk=5, -20, 7 → Y = 100, 105, 85, 92 on successive cycles; out_ch=1; out_valid high for 4 cycles; rd_acc at ch0/2/3 stays 0.
- Positive saturation (N=25): ch2 load 2^49-10, then accumulate 20 → Y=2^49-1 and ovf[2]=1. Then load 0 → Y=0 with ovf[2] still 1. Then select=10 → ovf[2]=0.
- Negative saturation: ch3 load -2^49+5, then accumulate -6 → Y=-2^49 and ovf[3]=1; ovf[0..2]=0.
- Interleaved channels: alternate ch0 and ch1 each cycle with accumulate Uk=1, 8 samples total → final rd_acc ch0=4 and ch1=4; out_ch alternates 0,1.
- Priority and boundaries:
  - clear_all and in_valid (ch0, load 55) in the same cycle → ch0=0, out_valid=0.
  - With CH=3, a sample to ch=3 → ignored, out_valid=0.
  - Async reset asserted mid-cycle during an accumulate burst → outputs clear before the next clk edge.

Source files
------------

// File: rtl/mux_ac_acum.sv
// Per-channel saturating accumulator bank fed by the coefficient multiplier.
// Each accepted sample loads, accumulates, clears or holds one channel; the result is registered one cycle later.
module mux_ac_acum #(
  parameter int N  = 25,
  parameter int CH = 4,
  parameter int CW = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_all,
  input  logic                  in_valid,
  input  logic [1:0]            select,
  input  logic [CW-1:0]         ch,
  input  logic signed [2*N-1:0] Uk,
  output logic signed [2*N-1:0] Y,
  output logic                  out_valid,
  output logic [CW-1:0]         out_ch,
  output logic [CH-1:0]         ovf,
  input  logic [CW-1:0]         rd_ch,
  output logic signed [2*N-1:0] rd_acc
);

  localparam int W = 2 * N;
  localparam logic signed [W-1:0] ACC_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] ACC_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [W-1:0] acc [CH];
  logic signed [W-1:0] cur;
  logic signed [W:0]   sum;
  logic signed [W-1:0] nxt;
  logic                accept;
  logic                sat_hit;

  assign accept = in_valid && ({1'b0, ch} < (CW+1)'(CH));

  always_comb begin
    cur = '0;
    for (int i = 0; i < CH; i++) begin
      if (ch == CW'(i)) cur = acc[i];
    end
  end

  // Sum kept one bit wider so overflow shows up as disagreement of the top two bits.
  always_comb begin
    sum     = {cur[W-1], cur} + {Uk[W-1], Uk};
    sat_hit = 1'b0;
    nxt     = cur;
    case (select)
      2'b00: nxt = Uk;
      2'b01: begin
        if (sum[W] != sum[W-1]) begin
          sat_hit = 1'b1;
          nxt     = sum[W] ? ACC_MIN : ACC_MAX;
        end else begin
          nxt = sum[W-1:0];
        end
      end
      2'b10: nxt = '0;
      default: nxt = cur;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < CH; i++) acc[i] <= '0;
      ovf       <= '0;
      Y         <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else if (clear_all) begin
      for (int i = 0; i < CH; i++) acc[i] <= '0;
      ovf       <= '0;
      Y         <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < CH; i++) begin
        if (ch == CW'(i)) begin
          acc[i] <= nxt;
          if (select == 2'b10)  ovf[i] <= 1'b0;
          else if (sat_hit)     ovf[i] <= 1'b1;
        end
      end
      Y         <= nxt;
      out_ch    <= ch;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    rd_acc = '0;
    for (int i = 0; i < CH; i++) begin
      if (rd_ch == CW'(i)) rd_acc = acc[i];
    end
  end

endmodule

// File: tb/tb_mux_ac_acum.sv
// Directed bench for mux_ac_acum: a reference model pushes expected results to a
// scoreboard queue when each sample is driven; they are popped when out_valid appears.
module tb_mux_ac_acum;

  localparam longint MAXL = (longint'(1) <<< 49) - 1;
  localparam longint MINL = -(longint'(1) <<< 49);
  localparam logic [49:0] YMAX = {1'b0, {49{1'b1}}};
  localparam logic [49:0] YMIN = {1'b1, {49{1'b0}}};

  logic               clk = 1'b0;
  logic               reset;
  logic               clear_all;
  logic               in_valid;
  logic [1:0]         select;
  logic [1:0]         ch;
  logic signed [49:0] Uk;
  logic [49:0]        Y;
  logic               out_valid;
  logic [1:0]         out_ch;
  logic [3:0]         ovf;
  logic [1:0]         rd_ch;
  logic [49:0]        rd_acc;

  logic               in_valid3;
  logic [1:0]         select3;
  logic [1:0]         ch3;
  logic signed [49:0] Uk3;
  logic [49:0]        Y3;
  logic               out_valid3;
  logic [1:0]         out_ch3;
  logic [2:0]         ovf3;
  logic [1:0]         rd_ch3;
  logic [49:0]        rd_acc3;

  typedef struct {
    logic [49:0] y;
    logic [1:0]  c;
  } exp_t;

  exp_t   q[$];
  longint macc [4];
  logic [3:0] movf;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_ac_acum #(.N(25), .CH(4), .CW(2)) dut (
    .clk(clk), .reset(reset), .clear_all(clear_all), .in_valid(in_valid),
    .select(select), .ch(ch), .Uk(Uk), .Y(Y), .out_valid(out_valid),
    .out_ch(out_ch), .ovf(ovf), .rd_ch(rd_ch), .rd_acc(rd_acc)
  );

  mux_ac_acum #(.N(25), .CH(3), .CW(2)) dut3 (
    .clk(clk), .reset(reset), .clear_all(1'b0), .in_valid(in_valid3),
    .select(select3), .ch(ch3), .Uk(Uk3), .Y(Y3), .out_valid(out_valid3),
    .out_ch(out_ch3), .ovf(ovf3), .rd_ch(rd_ch3), .rd_acc(rd_acc3)
  );

  task automatic chk(input string tag, input logic [49:0] obs, input logic [49:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic longint sat(input longint s);
    if (s > MAXL) return MAXL;
    if (s < MINL) return MINL;
    return s;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) macc[i] = 0;
    movf = '0;
  endfunction

  // Called at a negedge: drive one sample, let one rising edge pass, check at the next negedge.
  task automatic cycle(input logic v, input logic [1:0] s, input logic [1:0] c,
                       input longint u, input logic ca = 1'b0);
    longint n;
    longint sm;
    exp_t   e;
    in_valid  = v;
    select    = s;
    ch        = c;
    Uk        = 50'(u);
    clear_all = ca;
    if (ca) begin
      model_clear();
    end else if (v) begin
      sm = macc[c] + u;
      case (s)
        2'b00: n = u;
        2'b01: begin
          n = sat(sm);
          if (n != sm) movf[c] = 1'b1;
        end
        2'b10: begin
          n = 0;
          movf[c] = 1'b0;
        end
        default: n = macc[c];
      endcase
      macc[c] = n;
      e.y = 50'(n);
      e.c = c;
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("out_valid_hi", 50'(out_valid), 50'd1);
      chk("y_sb", Y, e.y);
      chk("out_ch_sb", 50'(out_ch), 50'(e.c));
    end else begin
      chk("out_valid_lo", 50'(out_valid), 50'd0);
    end
    if (ca) chk("clear_all_y", Y, 50'd0);
    chk("ovf", 50'(ovf), 50'(movf));
    in_valid  = 1'b0;
    clear_all = 1'b0;
  endtask

  initial begin
    reset = 1'b0; clear_all = 1'b0; in_valid = 1'b0; select = 2'b00; ch = 2'd0;
    Uk = '0; rd_ch = 2'd0;
    in_valid3 = 1'b0; select3 = 2'b00; ch3 = 2'd0; Uk3 = '0; rd_ch3 = 2'd0;
    model_clear();

    // Reset held with in_valid toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      select = 2'b00; ch = 2'(i); Uk = 50'(77 + i);
    end
    @(negedge clk);
    chk("rst_out_valid", 50'(out_valid), 50'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    chk("rst_y", Y, 50'd0);
    chk("rst_ovf", 50'(ovf), 50'd0);
    for (int i = 0; i < 4; i++) begin
      rd_ch = 2'(i);
      #1 chk("rst_rd_acc", rd_acc, 50'd0);
    end
    @(negedge clk);

    // Load then accumulate on ch1
    cycle(1, 2'b00, 2'd1, 100);  chk("la_y0", Y, 50'd100);
    cycle(1, 2'b01, 2'd1, 5);    chk("la_y1", Y, 50'd105);
    cycle(1, 2'b01, 2'd1, -20);  chk("la_y2", Y, 50'd85);
    cycle(1, 2'b01, 2'd1, 7);    chk("la_y3", Y, 50'd92);
    chk("la_out_ch", 50'(out_ch), 50'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) continue;
      rd_ch = 2'(i);
      #1 chk("la_other_ch", rd_acc, 50'd0);
    end
    cycle(0, 2'b01, 2'd1, 3);
    chk("idle_y_hold", Y, 50'd92);

    // Positive saturation on ch2
    cycle(1, 2'b00, 2'd2, MAXL - 9);
    cycle(1, 2'b01, 2'd2, 20);   chk("psat_y", Y, YMAX);
    chk("psat_ovf2", 50'(ovf[2]), 50'd1);
    cycle(1, 2'b00, 2'd2, 0);    chk("load_keeps_ovf", 50'(ovf[2]), 50'd1);
    chk("load0_y", Y, 50'd0);
    cycle(1, 2'b10, 2'd2, 0);    chk("clr_ovf2", 50'(ovf[2]), 50'd0);

    // Negative saturation on ch3
    cycle(1, 2'b00, 2'd3, MINL + 5);
    cycle(1, 2'b01, 2'd3, -6);   chk("nsat_y", Y, YMIN);
    chk("nsat_ovf", 50'(ovf), 50'h8);

    // Interleaved ch0/ch1 accumulate, starting from cleared ch1
    cycle(1, 2'b10, 2'd1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 2'b01, 2'(i % 2), 1);
    rd_ch = 2'd0; #1 chk("il_ch0", rd_acc, 50'd4);
    rd_ch = 2'd1; #1 chk("il_ch1", rd_acc, 50'd4);
    cycle(1, 2'b11, 2'd1, 999);  chk("hold_y", Y, 50'd4);

    // clear_all beats a coincident load
    cycle(1, 2'b00, 2'd0, 55, 1'b1);
    rd_ch = 2'd0; #1 chk("ca_ch0", rd_acc, 50'd0);
    rd_ch = 2'd3; #1 chk("ca_ch3", rd_acc, 50'd0);

    // Out-of-range channel on a 3-channel instance
    @(negedge clk);
    in_valid3 = 1'b1; select3 = 2'b00; ch3 = 2'd2; Uk3 = 50'sd9;
    @(posedge clk); @(negedge clk);
    chk("ch3_valid", 50'(out_valid3), 50'd1);
    chk("ch3_y", Y3, 50'd9);
    chk("ch3_out_ch", 50'(out_ch3), 50'd2);
    ch3 = 2'd3; Uk3 = 50'sd7;
    @(posedge clk); @(negedge clk);
    in_valid3 = 1'b0;
    chk("oor_valid", 50'(out_valid3), 50'd0);
    chk("oor_y_hold", Y3, 50'd9);
    chk("oor_ovf", 50'(ovf3), 50'd0);
    rd_ch3 = 2'd2; #1 chk("oor_rd2", rd_acc3, 50'd9);
    rd_ch3 = 2'd3; #1 chk("oor_rd3", rd_acc3, 50'd0);
    @(negedge clk);

    // Async reset mid-burst
    cycle(1, 2'b01, 2'd0, 1);    chk("burst_y1", Y, 50'd1);
    cycle(1, 2'b01, 2'd0, 1);    chk("burst_y2", Y, 50'd2);
    in_valid = 1'b1; select = 2'b01; ch = 2'd0; Uk = 50'sd1;
    @(posedge clk);
    #2 reset = 1'b0;
    rd_ch = 2'd0;
    #1;
    chk("arst_valid", 50'(out_valid), 50'd0);
    chk("arst_y", Y, 50'd0);
    chk("arst_rd", rd_acc, 50'd0);
    chk("arst_ovf", 50'(ovf), 50'd0);
    model_clear();
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    chk("sb_empty", 50'(q.size()), 50'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
